// File: rtl/cdc_sync_bus_filt.sv
// cdc_sync_bus_filt
// -----------------
// Multi-bit, N-stage synchroniser with a per-bit glitch filter and registered
// rise/fall strobes. Each of the WIDTH bits is handled independently; there is
// no cross-bit coherence, so multi-bit values must be Gray-coded or otherwise
// change one bit at a time.
//
// Parameters:
//   WIDTH         - number of independent input bits (>= 1)
//   STAGES        - synchroniser flop depth (>= 2)
//   FILTER_CYCLES - extra consecutive cycles a new synchronised value must hold
//                   before it is accepted (0 = no filtering)
//   RESET_VAL     - value loaded into every sync stage and dout on reset
//
// Ports:
//   clock   - destination clock, all flops on the rising edge
//   srst_n  - synchronous active-low reset
//   din     - asynchronous, quasi-static inputs
//   dout    - synchronised, filtered value
//   rise    - one-cycle strobe per bit when dout[i] goes 0->1
//   fall    - one-cycle strobe per bit when dout[i] goes 1->0
//   changed - OR of all rise and fall bits, same cycle

module cdc_sync_bus_filt #(
  parameter int unsigned       WIDTH         = 1,
  parameter int unsigned       STAGES        = 2,
  parameter int unsigned       FILTER_CYCLES = 0,
  parameter logic [WIDTH-1:0]  RESET_VAL     = '0
) (
  input  logic             clock,
  input  logic             srst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed
);

  // Elaboration-time parameter checks.
  if (STAGES < 2) begin : gen_stages_chk
    $error("cdc_sync_bus_filt: STAGES must be >= 2");
  end
  if (WIDTH < 1) begin : gen_width_chk
    $error("cdc_sync_bus_filt: WIDTH must be >= 1");
  end

  // Counter holds 0..FILTER_CYCLES; keep at least one bit so the logic stays
  // uniform when filtering is disabled.
  localparam int unsigned      CNT_W   = (FILTER_CYCLES == 0) ? 1 : $clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FILTER_CYCLES);

  // ---------------------------------------------------------------------------
  // Synchroniser chain. Only stage 0 can go metastable; nothing but the last
  // stage is ever read by downstream logic.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0] sync_q [STAGES];
  logic [WIDTH-1:0] s;

  always_ff @(posedge clock) begin
    if (!srst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        sync_q[k] <= RESET_VAL;
      end
    end else begin
      sync_q[0] <= din;
      for (int k = 1; k < STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  assign s = sync_q[STAGES-1];

  // ---------------------------------------------------------------------------
  // Per-bit filter. A bit is accepted only after s has differed from dout on
  // FILTER_CYCLES+1 consecutive edges; any reversion clears the count.
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];
  logic [WIDTH-1:0] dout_q, dout_d;
  logic [WIDTH-1:0] rise_q, rise_d;
  logic [WIDTH-1:0] fall_q, fall_d;
  logic             changed_q, changed_d;

  always_comb begin
    cnt_d  = cnt_q;
    dout_d = dout_q;
    rise_d = '0;
    fall_d = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (s[i] == dout_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_MAX) begin
        dout_d[i] = s[i];
        cnt_d[i]  = '0;
        rise_d[i] = s[i];
        fall_d[i] = ~s[i];
      end else begin
        cnt_d[i] = cnt_q[i] + 1'b1;
      end
    end
    changed_d = |(rise_d | fall_d);
  end

  always_ff @(posedge clock) begin
    if (!srst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        cnt_q[i] <= '0;
      end
      dout_q    <= RESET_VAL;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      dout_q    <= dout_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      changed_q <= changed_d;
    end
  end

  assign dout    = dout_q;
  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = changed_q;

endmodule

// File: tb/tb_cdc_sync_bus_filt.sv
// Bench for cdc_sync_bus_filt. Three configurations share one stimulus stream:
//   cfg0: STAGES=2 FILTER=0 RESET_VAL=0000
//   cfg1: STAGES=3 FILTER=3 RESET_VAL=1111
//   cfg2: STAGES=2 FILTER=1 RESET_VAL=0000
// Each configuration has a reference model built from a delay queue of din
// samples and a window of the last FILTER+1 synchronised values: a bit flips
// when every value in the window disagrees with the current output.

module tb_cdc_sync_bus_filt;

  localparam int unsigned NCFG = 3;
  localparam int unsigned ST  [NCFG] = '{2, 3, 2};
  localparam int unsigned FIL [NCFG] = '{0, 3, 1};
  localparam logic [3:0]  RV  [NCFG] = '{4'h0, 4'hF, 4'h0};

  logic       clock = 1'b0;
  logic       srst_n;
  logic [3:0] din;

  logic [3:0] dout_w    [NCFG];
  logic [3:0] rise_w    [NCFG];
  logic [3:0] fall_w    [NCFG];
  logic       changed_w [NCFG];

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Advance one edge and return 1 time unit later, outputs settled.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : gen_cfg
    cdc_sync_bus_filt #(
      .WIDTH        (4),
      .STAGES       (ST[g]),
      .FILTER_CYCLES(FIL[g]),
      .RESET_VAL    (RV[g])
    ) u_dut (
      .clock  (clock),
      .srst_n (srst_n),
      .din    (din),
      .dout   (dout_w[g]),
      .rise   (rise_w[g]),
      .fall   (fall_w[g]),
      .changed(changed_w[g])
    );

    // Reference model state.
    logic [3:0] pipe [$];  // din samples; pipe[0] is the synchronised value
    logic [3:0] win  [$];  // synchronised values seen at the last FILTER+1 edges
    logic [3:0] m_dout, m_rise, m_fall, s_pre;
    bit         m_valid = 1'b0;
    bit         all_diff;

    always @(posedge clock) begin
      if (!srst_n) begin
        pipe.delete();
        win.delete();
        for (int k = 0; k < int'(ST[g]); k++) pipe.push_back(RV[g]);
        for (int k = 0; k <= int'(FIL[g]); k++) win.push_back(RV[g]);
        m_dout  = RV[g];
        m_rise  = '0;
        m_fall  = '0;
        m_valid = 1'b1;
      end else if (m_valid) begin
        s_pre = pipe.pop_front();
        pipe.push_back(din);
        win.push_back(s_pre);
        void'(win.pop_front());
        m_rise = '0;
        m_fall = '0;
        for (int i = 0; i < 4; i++) begin
          all_diff = 1'b1;
          foreach (win[j]) if (win[j][i] == m_dout[i]) all_diff = 1'b0;
          if (all_diff) begin
            m_dout[i] = ~m_dout[i];
            if (m_dout[i]) m_rise[i] = 1'b1;
            else           m_fall[i] = 1'b1;
          end
        end
      end
    end

    always @(negedge clock) begin
      if (m_valid) begin
        check($sformatf("cfg%0d dout", g), dout_w[g], m_dout);
        check($sformatf("cfg%0d rise", g), rise_w[g], m_rise);
        check($sformatf("cfg%0d fall", g), fall_w[g], m_fall);
        check($sformatf("cfg%0d changed", g), {3'b000, changed_w[g]},
              {3'b000, |(m_rise | m_fall)});
      end
    end
  end

  initial begin
    srst_n = 1'b0;
    din    = 4'b0101;

    // Reset with din != RESET_VAL.
    repeat (3) tick();
    check("rst cfg1 dout", dout_w[1], 4'hF);
    check("rst cfg1 fall", fall_w[1], 4'h0);
    check("rst cfg1 rise", rise_w[1], 4'h0);
    check("rst cfg0 dout", dout_w[0], 4'h0);

    // Release: edge r is the first edge with srst_n high.
    srst_n = 1'b1;
    repeat (3) tick();                          // edge r+2
    check("rel cfg0 rise", rise_w[0], 4'b0101);
    check("rel cfg0 changed", {3'b000, changed_w[0]}, 4'b0001);
    check("rel cfg2 rise early", rise_w[2], 4'b0000);
    tick();                                     // r+3
    check("rel cfg2 rise", rise_w[2], 4'b0101);
    repeat (2) tick();                          // r+5
    check("rel cfg1 dout early", dout_w[1], 4'hF);
    check("rel cfg1 fall early", fall_w[1], 4'h0);
    tick();                                     // r+6
    check("rel cfg1 fall", fall_w[1], 4'b1010);
    check("rel cfg1 dout", dout_w[1], 4'b0101);

    // Multi-bit change on cfg2 (FILTER=1): both changes accept 4 edges later.
    din = 4'b0000;
    repeat (12) tick();
    din = 4'b1010;                              // captured at e+1
    repeat (3) tick();
    check("multi cfg2 rise early", rise_w[2], 4'b0000);
    tick();                                     // e+4
    check("multi cfg2 rise1", rise_w[2], 4'b1010);
    check("multi cfg2 changed1", {3'b000, changed_w[2]}, 4'b0001);
    din = 4'b0110;
    repeat (4) tick();                          // e+8
    check("multi cfg2 rise2", rise_w[2], 4'b0100);
    check("multi cfg2 fall2", fall_w[2], 4'b1000);
    check("multi cfg2 changed2", {3'b000, changed_w[2]}, 4'b0001);

    // Short glitch on cfg1 (FILTER=3) must be rejected.
    din = 4'b0000;
    repeat (12) tick();
    din = 4'b0001;
    repeat (2) tick();
    din = 4'b0000;
    repeat (12) tick();
    check("glitch cfg1 dout", dout_w[1], 4'b0000);

    // High 3 cycles, low 1, high again: count restarts.
    din = 4'b0001;                              // after edge e0
    repeat (3) tick();
    din = 4'b0000;
    tick();                                     // e0+4
    din = 4'b0001;
    repeat (6) tick();                          // e0+10
    check("restart cfg1 dout early", dout_w[1], 4'b0000);
    tick();                                     // e0+11
    check("restart cfg1 rise", rise_w[1], 4'b0001);
    check("restart cfg1 dout", dout_w[1], 4'b0001);

    // Reset while cfg1 bit0 count is 2.
    repeat (10) tick();
    din = 4'b0000;                              // after edge e0
    repeat (5) tick();                          // e0+5, cnt reached 2
    srst_n = 1'b0;
    tick();                                     // reset edge
    check("midrst cfg1 dout", dout_w[1], 4'hF);
    check("midrst cfg1 rise", rise_w[1], 4'h0);
    check("midrst cfg1 fall", fall_w[1], 4'h0);
    srst_n = 1'b1;
    repeat (6) tick();                          // r+5
    check("midrst cfg1 fall early", fall_w[1], 4'h0);
    tick();                                     // r+6
    check("midrst cfg1 fall", fall_w[1], 4'hF);

    // Randomised phase with occasional resets.
    for (int n = 0; n < 3000; n++) begin
      srst_n = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 2) == 0) din[$urandom_range(0, 3)] ^= 1'b1;
      tick();
    end
    srst_n = 1'b1;
    repeat (10) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
